// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and the load-value check for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    StDisarmed,
    StArmed,
    StRinging,
    StSnooze
  } alarm_state_e;

  localparam logic [3:0] HH_MAX_T      = 4'd2;
  localparam logic [3:0] HH_MAX_U_AT_2 = 4'd3;
  localparam logic [3:0] MM_MAX_T      = 4'd5;
  localparam logic [3:0] BCD_MAX       = 4'd9;

  // HH:MM in BCD: every digit a decimal digit, hours 00..23, minute tens 0..5.
  function automatic logic alarm_time_valid(input logic [15:0] val);
    logic [3:0] hh_t, hh_u, mm_t, mm_u;
    hh_t = val[15:12];
    hh_u = val[11:8];
    mm_t = val[7:4];
    mm_u = val[3:0];
    return (hh_t <= HH_MAX_T) && (hh_u <= BCD_MAX) && (mm_t <= MM_MAX_T) &&
           (mm_u <= BCD_MAX) && !((hh_t == HH_MAX_T) && (hh_u > HH_MAX_U_AT_2));
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Buzzer square-wave divider: toggles every TONE_DIV enabled cycles, clears when disabled.
module alarm_tone_gen #(
  parameter int unsigned TONE_DIV = 25000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tone_o
);

  localparam int unsigned CntW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TONE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!en_i) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores an HH:MM alarm, matches it against the BCD time counter and
// runs the ring / snooze / stop state machine driving the LED and buzzer.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TONE_DIV    = 25000,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        tick_1s,
  input  logic [3:0]  t_hh_t,
  input  logic [3:0]  t_hh_u,
  input  logic [3:0]  t_mm_t,
  input  logic [3:0]  t_mm_u,
  input  logic [3:0]  t_ss_t,
  input  logic [3:0]  t_ss_u,
  input  logic [15:0] set_val,
  input  logic        set_load,
  input  logic        arm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic [3:0]  alm_hh_t,
  output logic [3:0]  alm_hh_u,
  output logic [3:0]  alm_mm_t,
  output logic [3:0]  alm_mm_u,
  output logic        ringing,
  output logic        alarm_led,
  output logic        buzzer,
  output logic        set_err
);

  localparam int unsigned RingW = $clog2(RING_SECS + 1);
  localparam int unsigned SnzW  = $clog2(SNOOZE_SECS + 1);
  localparam logic [RingW-1:0] RingMax = RingW'(RING_SECS);
  localparam logic [SnzW-1:0]  SnzMax  = SnzW'(SNOOZE_SECS);

  logic             tick_d_q;
  logic [15:0]      alarm_q;
  logic             set_err_q;
  alarm_state_e     state_q;
  logic [RingW-1:0] ring_cnt_q;
  logic [SnzW-1:0]  snz_cnt_q;
  logic             led_q;

  logic             load_ok;
  logic             match;
  logic [RingW-1:0] ring_inc;
  logic [SnzW-1:0]  snz_inc;
  logic             tone;

  assign load_ok  = set_load && alarm_time_valid(set_val);
  // Digits are compared one cycle after the tick so the counter has already advanced.
  assign match    = tick_d_q && ({t_hh_t, t_hh_u, t_mm_t, t_mm_u} == alarm_q) &&
                    (t_ss_t == 4'd0) && (t_ss_u == 4'd0);
  assign ring_inc = ring_cnt_q + RingW'(1);
  assign snz_inc  = snz_cnt_q + SnzW'(1);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      tick_d_q  <= 1'b0;
      alarm_q   <= '0;
      set_err_q <= 1'b0;
    end else begin
      tick_d_q <= tick_1s;
      if (set_load) begin
        if (load_ok) begin
          alarm_q <= set_val;
        end
        set_err_q <= ~load_ok;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= StDisarmed;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      led_q      <= 1'b0;
    end else if (!arm_en) begin
      state_q <= StDisarmed;
      led_q   <= 1'b0;
    end else begin
      case (state_q)
        StDisarmed: begin
          state_q <= StArmed;
        end
        StArmed: begin
          if (match && !load_ok) begin
            state_q    <= StRinging;
            ring_cnt_q <= '0;
            led_q      <= 1'b1;
          end
        end
        StRinging: begin
          if (load_ok || stop) begin
            state_q <= StArmed;
            led_q   <= 1'b0;
          end else if (snooze) begin
            state_q   <= StSnooze;
            snz_cnt_q <= '0;
            led_q     <= 1'b0;
          end else if (tick_d_q) begin
            ring_cnt_q <= ring_inc;
            if (ring_inc == RingMax) begin
              state_q <= StArmed;
              led_q   <= 1'b0;
            end else begin
              led_q <= ~led_q;
            end
          end
        end
        StSnooze: begin
          if (load_ok || stop) begin
            state_q <= StArmed;
          end else if (tick_d_q) begin
            snz_cnt_q <= snz_inc;
            if (snz_inc == SnzMax) begin
              state_q    <= StRinging;
              ring_cnt_q <= '0;
              led_q      <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StDisarmed;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  alarm_tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone_gen (
    .clk_i (CLOCK_50),
    .rst_ni(RESET_N),
    .en_i  (state_q == StRinging),
    .tone_o(tone)
  );

  assign alm_hh_t  = alarm_q[15:12];
  assign alm_hh_u  = alarm_q[11:8];
  assign alm_mm_t  = alarm_q[7:4];
  assign alm_mm_u  = alarm_q[3:0];
  assign ringing   = (state_q == StRinging);
  assign alarm_led = led_q;
  // The divider clears a cycle after RINGING ends; gate so the pin drops with the state.
  assign buzzer    = tone && (state_q == StRinging);
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scenario bench for alarm_ctrl with a small arithmetic model of alarm-time loads.
module tb_alarm_ctrl;

  localparam int unsigned TONE_DIV    = 4;
  localparam int unsigned RING_SECS   = 8;
  localparam int unsigned SNOOZE_SECS = 5;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        tick_1s  = 1'b0;
  logic [3:0]  t_hh_t = '0, t_hh_u = '0, t_mm_t = '0, t_mm_u = '0, t_ss_t = '0, t_ss_u = '0;
  logic [15:0] set_val  = '0;
  logic        set_load = 1'b0;
  logic        arm_en   = 1'b0;
  logic        snooze   = 1'b0;
  logic        stop     = 1'b0;
  logic [3:0]  alm_hh_t, alm_hh_u, alm_mm_t, alm_mm_u;
  logic        ringing, alarm_led, buzzer, set_err;
  logic [15:0] alm;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_alarm = '0;
  logic        m_err   = 1'b0;

  assign alm = {alm_hh_t, alm_hh_u, alm_mm_t, alm_mm_u};

  alarm_ctrl #(
    .TONE_DIV   (TONE_DIV),
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .tick_1s  (tick_1s),
    .t_hh_t   (t_hh_t),
    .t_hh_u   (t_hh_u),
    .t_mm_t   (t_mm_t),
    .t_mm_u   (t_mm_u),
    .t_ss_t   (t_ss_t),
    .t_ss_u   (t_ss_u),
    .set_val  (set_val),
    .set_load (set_load),
    .arm_en   (arm_en),
    .snooze   (snooze),
    .stop     (stop),
    .alm_hh_t (alm_hh_t),
    .alm_hh_u (alm_hh_u),
    .alm_mm_t (alm_mm_t),
    .alm_mm_u (alm_mm_u),
    .ringing  (ringing),
    .alarm_led(alarm_led),
    .buzzer   (buzzer),
    .set_err  (set_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Decimal view of a BCD alarm value: hours 0..23, minutes 0..59, digits 0..9.
  function automatic logic model_valid(input logic [15:0] v);
    int ht, hu, mt, mu;
    ht = int'(v[15:12]);
    hu = int'(v[11:8]);
    mt = int'(v[7:4]);
    mu = int'(v[3:0]);
    return (ht <= 9) && (hu <= 9) && (mt <= 9) && (mu <= 9) &&
           ((ht * 10 + hu) <= 23) && ((mt * 10 + mu) <= 59);
  endfunction

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic drive_time(input int hh, input int mm, input int ss);
    t_hh_t = 4'(hh / 10);
    t_hh_u = 4'(hh % 10);
    t_mm_t = 4'(mm / 10);
    t_mm_u = 4'(mm % 10);
    t_ss_t = 4'(ss / 10);
    t_ss_u = 4'(ss % 10);
  endtask

  // Tick with the new time; returns two cycles later, when a match has taken effect.
  task automatic tick_at(input int hh, input int mm, input int ss);
    drive_time(hh, mm, ss);
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
    cyc();
  endtask

  task automatic load(input logic [15:0] v);
    set_val  = v;
    set_load = 1'b1;
    cyc();
    set_load = 1'b0;
    if (model_valid(v)) m_alarm = v;
    m_err = ~model_valid(v);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    idle(3);
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL reset_ringing: got %b want 0", ringing); end
    n_tests++; if (alarm_led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0", alarm_led); end
    n_tests++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    n_tests++; if (set_err !== 1'b0) begin n_fail++; $display("FAIL reset_set_err: got %b want 0", set_err); end
    n_tests++; if (alm !== 16'h0000) begin n_fail++; $display("FAIL reset_alarm: got %h want 0000", alm); end
    RESET_N = 1'b1;
    cyc();
  endtask

  task automatic test_match();
    load(16'h0730);
    n_tests++; if (alm !== m_alarm) begin n_fail++; $display("FAIL load_0730: got %h want %h", alm, m_alarm); end
    arm_en = 1'b1;
    idle(2);
    tick_at(7, 29, 59);
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL early_ring: got %b want 0", ringing); end
    idle(3);
    drive_time(7, 30, 0);
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL latency_n1: got %b want 0", ringing); end
    cyc();
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL latency_n2: got %b want 1", ringing); end
    n_tests++; if (alarm_led !== 1'b1) begin n_fail++; $display("FAIL ring_led: got %b want 1", alarm_led); end
    for (int k = 0; k < 3 * int'(TONE_DIV); k++) begin
      n_tests++;
      if (buzzer !== 1'((k / int'(TONE_DIV)) % 2)) begin
        n_fail++; $display("FAIL buzzer_wave k=%0d: got %b want %0d", k, buzzer, (k / int'(TONE_DIV)) % 2);
      end
      cyc();
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= int'(RING_SECS); k++) begin
      idle($urandom_range(2, 5));
      tick_at(7, 30, k);
      if (k < int'(RING_SECS)) begin
        n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_hold k=%0d: got %b want 1", k, ringing); end
        n_tests++; if (alarm_led !== 1'(k % 2 == 0)) begin n_fail++; $display("FAIL led_blink k=%0d: got %b want %b", k, alarm_led, 1'(k % 2 == 0)); end
      end else begin
        n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL timeout_ring: got %b want 0", ringing); end
        n_tests++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL timeout_buzzer: got %b want 0", buzzer); end
        n_tests++; if (alarm_led !== 1'b0) begin n_fail++; $display("FAIL timeout_led: got %b want 0", alarm_led); end
      end
    end
    idle(3);
    tick_at(7, 30, 0);
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL timeout_armed: got %b want 1", ringing); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL stop_ring: got %b want 0", ringing); end
  endtask

  task automatic test_set_err();
    logic [15:0] v;
    load(16'h2400);
    n_tests++; if (set_err !== 1'b1) begin n_fail++; $display("FAIL err_2400: got %b want 1", set_err); end
    n_tests++; if (alm !== 16'h0730) begin n_fail++; $display("FAIL keep_2400: got %h want 0730", alm); end
    load(16'h1275);
    n_tests++; if (set_err !== 1'b1) begin n_fail++; $display("FAIL err_1275: got %b want 1", set_err); end
    n_tests++; if (alm !== 16'h0730) begin n_fail++; $display("FAIL keep_1275: got %h want 0730", alm); end
    load(16'h0615);
    n_tests++; if (set_err !== 1'b0) begin n_fail++; $display("FAIL err_0615: got %b want 0", set_err); end
    n_tests++; if (alm !== 16'h0615) begin n_fail++; $display("FAIL load_0615: got %h want 0615", alm); end
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) v = 16'($urandom);
      else v = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      load(v);
      n_tests++; if (alm !== m_alarm) begin n_fail++; $display("FAIL rand_alarm v=%h: got %h want %h", v, alm, m_alarm); end
      n_tests++; if (set_err !== m_err) begin n_fail++; $display("FAIL rand_err v=%h: got %b want %b", v, set_err, m_err); end
    end
    load(16'h0615);
    n_tests++; if (alm !== 16'h0615) begin n_fail++; $display("FAIL reload_0615: got %h want 0615", alm); end
  endtask

  task automatic test_snooze();
    tick_at(6, 15, 0);
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL snz_ring: got %b want 1", ringing); end
    idle(2);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL snz_enter: got %b want 0", ringing); end
    n_tests++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL snz_buzzer: got %b want 0", buzzer); end
    n_tests++; if (alarm_led !== 1'b0) begin n_fail++; $display("FAIL snz_led: got %b want 0", alarm_led); end
    for (int k = 1; k <= int'(SNOOZE_SECS); k++) begin
      idle($urandom_range(2, 6));
      tick_at(6, 15, k);
      if (k < int'(SNOOZE_SECS)) begin
        n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL snz_hold k=%0d: got %b want 0", k, ringing); end
      end else begin
        n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL snz_expire: got %b want 1", ringing); end
        n_tests++; if (alarm_led !== 1'b1) begin n_fail++; $display("FAIL snz_expire_led: got %b want 1", alarm_led); end
      end
    end
  endtask

  task automatic test_stop_snooze();
    idle(2);
    stop   = 1'b1;
    snooze = 1'b1;
    cyc();
    stop   = 1'b0;
    snooze = 1'b0;
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL stop_snz: got %b want 0", ringing); end
    for (int k = 1; k <= int'(SNOOZE_SECS) + 1; k++) begin
      idle(2);
      tick_at(6, 15, 10 + k);
      n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL stop_not_snz k=%0d: got %b want 0", k, ringing); end
    end
    tick_at(6, 15, 0);
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL stop_armed: got %b want 1", ringing); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    arm_en = 1'b0;
    cyc();
    load(16'h0820);
    n_tests++; if (set_err !== 1'b0) begin n_fail++; $display("FAIL load_0820: got %b want 0", set_err); end
    idle(2);
    tick_at(8, 20, 0);
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL disarmed_ring: got %b want 0", ringing); end
    idle(5);
    n_tests++; if (alarm_led !== 1'b0) begin n_fail++; $display("FAIL disarmed_led: got %b want 0", alarm_led); end
  endtask

  task automatic test_priority();
    arm_en = 1'b1;
    idle(2);
    tick_at(8, 20, 0);
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL rearm_ring: got %b want 1", ringing); end
    load(16'h0820);
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL load_stops_ring: got %b want 0", ringing); end
    idle(2);
    tick_at(8, 20, 0);
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL reload_ring: got %b want 1", ringing); end
    arm_en = 1'b0;
    cyc();
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL disarm_ring: got %b want 0", ringing); end
    n_tests++; if (alarm_led !== 1'b0) begin n_fail++; $display("FAIL disarm_led: got %b want 0", alarm_led); end
    arm_en = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid_ring();
    tick_at(8, 20, 0);
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL mid_ring: got %b want 1", ringing); end
    idle(TONE_DIV);
    n_tests++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL mid_buzzer: got %b want 1", buzzer); end
    load(16'hFFFF);
    n_tests++; if (set_err !== 1'b1) begin n_fail++; $display("FAIL mid_err: got %b want 1", set_err); end
    n_tests++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL bad_load_keeps_ring: got %b want 1", ringing); end
    RESET_N = 1'b0;
    cyc();
    n_tests++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL rst_ringing: got %b want 0", ringing); end
    n_tests++; if (alarm_led !== 1'b0) begin n_fail++; $display("FAIL rst_led: got %b want 0", alarm_led); end
    n_tests++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL rst_buzzer: got %b want 0", buzzer); end
    n_tests++; if (set_err !== 1'b0) begin n_fail++; $display("FAIL rst_set_err: got %b want 0", set_err); end
    n_tests++; if (alm !== 16'h0000) begin n_fail++; $display("FAIL rst_alarm: got %h want 0000", alm); end
    RESET_N = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_match();
    test_timeout();
    test_set_err();
    test_snooze();
    test_stop_snooze();
    test_priority();
    test_reset_mid_ring();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller downstream of the BCD time-of-day counter. It consumes the counter's six BCD digits and its 1 Hz tick, holds a user-programmed HH:MM alarm time, and drives an alarm LED and a square-wave buzzer. It runs a ring / snooze / stop state machine with a programmable ring timeout. Load values come from the slide switches; snooze and stop come from debounced key pulses.

## Interface
Parameters:
- TONE_DIV, 25000: `CLOCK_50` cycles per buzzer half-period (1 kHz tone at 50 MHz).
- RING_SECS, 60: ticks the alarm rings before it stops on its own.
- SNOOZE_SECS, 300: ticks spent in snooze before ringing again.

Ports:
- `CLOCK_50` in 1: system clock. All logic is on its rising edge.
- `RESET_N` in 1: synchronous, active-low reset.
- `tick_1s` in 1: one-cycle pulse, once per second, from the time counter.
- `t_hh_t`, `t_hh_u`, `t_mm_t`, `t_mm_u`, `t_ss_t`, `t_ss_u` in 4 each: current time as BCD digits.
- `set_val` in 16: alarm time as BCD. [15:12] is hour tens, [11:8] hour units, [7:4] minute tens, [3:0] minute units.
- `set_load` in 1: one-cycle pulse that loads `set_val`.
- `arm_en` in 1: level input. 1 arms the alarm.
- `snooze` in 1: one-cycle pulse.
- `stop` in 1: one-cycle pulse.
- `alm_hh_t`, `alm_hh_u`, `alm_mm_t`, `alm_mm_u` out 4 each: stored alarm time, driven to the 7-seg decoders.
- `ringing` out 1: high while in RINGING.
- `alarm_led` out 1: blinks at 0.5 Hz while RINGING.
- `buzzer` out 1: square wave while RINGING, otherwise 0.
- `set_err` out 1: sticky flag for an invalid load.

## Operation
Reset state:
- Alarm register = 00:00.
- State = DISARMED.
- `ringing`, `alarm_led`, `buzzer` and `set_err` = 0.
- Counters = 0.

Load:
- On `set_load`, `set_val` is valid only if every digit is ≤9, HH ≤ 23 and MM tens ≤ 5.
- Valid load: update the register, clear `set_err`. If the state is RINGING or SNOOZE, go to ARMED.
- Invalid load: register unchanged, `set_err` = 1.

Match:
- `tick_d` is `tick_1s` delayed by one cycle. Time digits are compared on the `tick_d` cycle, after the counter has updated.
- Match condition: HH:MM equals the register and SS = 00.

States:
- DISARMED:
  - `arm_en` = 1 → ARMED.
- ARMED:
  - `arm_en` = 0 → DISARMED.
  - match → RINGING. `ring_cnt` = 0, `alarm_led` = 1.
- RINGING:
  - Each `tick_d` toggles `alarm_led` and increments `ring_cnt`.
  - `ring_cnt` reaching RING_SECS → ARMED.
  - `snooze` → SNOOZE, `snz_cnt` = 0.
  - `stop` → ARMED.
- SNOOZE:
  - Each `tick_d` increments `snz_cnt`.
  - `snz_cnt` reaching SNOOZE_SECS → RINGING, `ring_cnt` = 0.
  - `stop` → ARMED.

Priority, highest first, when several events hit in one cycle:
1. `RESET_N`
2. `arm_en` = 0 (→ DISARMED from any state)
3. valid `set_load`
4. `stop`
5. `snooze`
6. counter expiry / match

Other rules:
- `alarm_led` and `buzzer` are forced to 0 in every state except RINGING.
- Buzzer: a tone counter counts 0..TONE_DIV-1 and toggles `buzzer` on wrap. It runs only in RINGING and is cleared when RINGING is left.
- Counter widths are $clog2(PARAM+1). They never wrap, because expiry forces a state exit.
- A match while in RINGING or SNOOZE is ignored.
- Re-trigger in the same minute cannot happen, because SS = 00 occurs on only one tick per minute.

## Timing
- Match latency: `tick_1s` at cycle N → `tick_d` at N+1 → `ringing` = 1 at N+2.
- `stop`, `snooze` or `set_load` at cycle N → state and outputs change at N+1.
- The `arm_en` level is sampled every cycle, with one cycle of latency.
- Alarm digit outputs change the cycle after a valid load.
- `set_err` updates the cycle after the load pulse.
- Reset mid-ring: all outputs go to their reset values on the next edge with `RESET_N` = 0.

## Structure
- Package `alarm_pkg` holds:
  - the state typedef (DISARMED, ARMED, RINGING, SNOOZE);
  - BCD limit constants HH_MAX_T = 2, HH_MAX_U_AT_2 = 3, MM_MAX_T = 5.
- One sub-module, `alarm_tone_gen`: TONE_DIV divider with an enable input, clearing to 0 when disabled.
- Everything else is in `alarm_ctrl`.

## Test plan
- Load 07:30 with `arm_en` = 1. Drive time 07:29:59 → 07:30:00. `ringing` = 1 exactly 2 cycles after that tick, and `buzzer` toggles every TONE_DIV cycles.
- Load 24:00, then 12:75. `set_err` = 1 both times and alarm digits stay 07:30. Then load 06:15: `set_err` = 0.
- Let the alarm ring untouched. After RING_SECS ticks, `ringing` = 0, `buzzer` = 0, state = ARMED.
- Pulse `snooze` while ringing. `ringing` = 0 the next cycle, and returns to 1 after SNOOZE_SECS ticks (use SNOOZE_SECS = 5 in sim).
- Assert `stop` and `snooze` in the same cycle while ringing. State = ARMED. Then drop `arm_en`: a match at the next set time produces no ring.
- Assert `RESET_N` = 0 mid-ring. All outputs = 0 and alarm register = 00:00 after one edge.
